qpel_mc: RTL and testbench

//  Quarter-pel motion compensator. It is the consumer end of the fme search result.
//  - Takes an integer position plus a quarter-pel fraction, i.e. the (pix_pos, quat_best) pair fme produces.
//  - Reads a reference line buffer that it owns.
//  - Streams BLK bilinearly interpolated prediction pixels out over a valid/ready handshake.
//  - Sits between the motion search and the residual/reconstruction stage.

---
 rtl/qpel_mc.sv | 150 +++++++++++++++
 tb/tb_qpel_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpel_mc.sv
// rtl/qpel_mc.sv - quarter-pel bilinear motion compensator streaming BLK prediction pixels
// QPEL_MC_ROUND_EN defined: round-half-up (R=2); undefined: truncate (R=0).
module qpel_mc #(
    parameter int BLK  = 8,
    parameter int AW   = 8,
    parameter int LINE = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ref_we,
    input  logic [AW-1:0] ref_addr,
    input  logic [7:0]    ref_data,
    input  logic          mv_valid,
    output logic          mv_ready,
    input  logic [AW-1:0] mv_pos,
    input  logic [1:0]    mv_frac,
    output logic          pred_valid,
    input  logic          pred_ready,
    output logic [7:0]    pred_data,
    output logic          pred_last,
    output logic          busy
);

    localparam int SW = AW + 4;
    localparam int IW = $clog2(BLK) + 1;

`ifdef QPEL_MC_ROUND_EN
    localparam logic [9:0] RND = 10'd2;
`else
    localparam logic [9:0] RND = 10'd0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pos_q, pos_d;
    logic [1:0]      frac_q, frac_d;
    logic [IW-1:0]   i_q, i_d;
    logic            pred_valid_q, pred_valid_d;
    logic [7:0]      pred_data_q, pred_data_d;
    logic            pred_last_q, pred_last_d;
    logic [7:0]      ref_mem_q [LINE];
    logic [7:0]      ref_mem_d [LINE];

    logic [SW-1:0]   sum_a, sum_b;
    logic [AW-1:0]   idx_a, idx_b;
    logic [9:0]      pix_a, pix_b, acc;
    logic [7:0]      sample;

    assign busy       = (state_q != IDLE);
    assign mv_ready   = (state_q == IDLE);
    assign pred_valid = pred_valid_q;
    assign pred_data  = pred_data_q;
    assign pred_last  = pred_last_q;

    // Reference writes are locked out for the whole life of a block so it reads a stable line.
    always_comb begin
        ref_mem_d = ref_mem_q;
        if (ref_we && !busy) begin
            ref_mem_d[ref_addr] = ref_data;
        end
    end

    always_ff @(posedge clk) begin
        ref_mem_q <= ref_mem_d;
    end

    // Neighbour indices are widened before clamping so blocks near the line end repeat the last pixel.
    always_comb begin
        sum_a = {4'b0000, pos_q} + SW'(i_q);
        sum_b = sum_a + SW'(1);
        idx_a = (sum_a > SW'(LINE - 1)) ? AW'(LINE - 1) : sum_a[AW-1:0];
        idx_b = (sum_b > SW'(LINE - 1)) ? AW'(LINE - 1) : sum_b[AW-1:0];
        pix_a = {2'b00, ref_mem_q[idx_a]};
        pix_b = {2'b00, ref_mem_q[idx_b]};
        case (frac_q)
            2'd1:    acc = pix_a + pix_a + pix_a + pix_b + RND;
            2'd2:    acc = pix_a + pix_a + pix_b + pix_b + RND;
            2'd3:    acc = pix_a + pix_b + pix_b + pix_b + RND;
            default: acc = {pix_a[7:0], 2'b00};
        endcase
        sample = acc[9:2];
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        frac_d       = frac_q;
        i_d          = i_q;
        pred_valid_d = pred_valid_q;
        pred_data_d  = pred_data_q;
        pred_last_d  = pred_last_q;
        case (state_q)
            IDLE: begin
                if (mv_valid) begin
                    pos_d   = mv_pos;
                    frac_d  = mv_frac;
                    i_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!pred_valid_q || pred_ready) begin
                    pred_valid_d = 1'b1;
                    pred_data_d  = sample;
                    pred_last_d  = (i_q == IW'(BLK - 1));
                    i_d          = i_q + IW'(1);
                    if (i_q == IW'(BLK - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pred_valid_q && pred_ready) begin
                    pred_valid_d = 1'b0;
                    pred_last_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            frac_q       <= '0;
            i_q          <= '0;
            pred_valid_q <= 1'b0;
            pred_data_q  <= '0;
            pred_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            frac_q       <= frac_d;
            i_q          <= i_d;
            pred_valid_q <= pred_valid_d;
            pred_data_q  <= pred_data_d;
            pred_last_q  <= pred_last_d;
        end
    end

endmodule

// File: tb/tb_qpel_mc.sv
// tb/tb_qpel_mc.sv - scoreboard bench for qpel_mc with a reference line model
module tb_qpel_mc;

    localparam int BLK  = 8;
    localparam int AW   = 8;
    localparam int LINE = 256;
`ifdef QPEL_MC_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ref_we;
    logic [7:0] ref_addr;
    logic [7:0] ref_data;
    logic       mv_valid;
    logic       mv_ready;
    logic [7:0] mv_pos;
    logic [1:0] mv_frac;
    logic       pred_valid;
    logic       pred_ready;
    logic [7:0] pred_data;
    logic       pred_last;
    logic       busy;

    always #5 clk = ~clk;

    qpel_mc #(.BLK(BLK), .AW(AW), .LINE(LINE)) dut (
        .clk(clk), .rst(rst),
        .ref_we(ref_we), .ref_addr(ref_addr), .ref_data(ref_data),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_pos(mv_pos), .mv_frac(mv_frac),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data),
        .pred_last(pred_last), .busy(busy)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    exp_t  sb[$];
    dchk_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    popped = 0;
    bit    force_low = 1'b0;
    bit    rand_rdy  = 1'b0;
    int    ref_m [LINE];

    // Single checking process: drains directed observations and scores every accepted pixel.
    initial begin
        dchk_t d;
        exp_t  e;
        forever begin
            @(negedge clk);
            while (dq.size() > 0) begin
                d = dq.pop_front();
                checks++;
                if (d.act != d.exp) begin
                    errors++;
                    $display("FAIL %s actual=%0d expected=%0d", d.name, d.act, d.exp);
                end
            end
            if (pred_valid && pred_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel actual=%0d expected=none", pred_data);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    if (int'(pred_data) != e.data || pred_last != e.last) begin
                        errors++;
                        $display("FAIL pixel actual=%0d/last%0d expected=%0d/last%0d",
                                 pred_data, pred_last, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        pred_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            pred_ready = force_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic void dchk(string n, int a, int e);
        dchk_t t;
        t.name = n;
        t.act  = a;
        t.exp  = e;
        dq.push_back(t);
    endfunction

    function automatic int clampi(int v);
        return (v > LINE - 1) ? LINE - 1 : v;
    endfunction

    function automatic int exp_pix(int pos, int frac, int i);
        int a;
        int b;
        a = ref_m[clampi(pos + i)];
        b = ref_m[clampi(pos + i + 1)];
        if (frac == 0) return a;
        return ((4 - frac) * a + frac * b + RND) / 4;
    endfunction

    function automatic void push_exp(int d, bit l);
        exp_t t;
        t.data = d;
        t.last = l;
        sb.push_back(t);
    endfunction

    function automatic void push_block(int pos, int frac);
        for (int i = 0; i < BLK; i++) push_exp(exp_pix(pos, frac, i), i == BLK - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ref(int a, int d);
        ref_we   = 1'b1;
        ref_addr = a[7:0];
        ref_data = d[7:0];
        tick();
        ref_we   = 1'b0;
        ref_m[a] = d & 255;
    endtask

    task automatic fill_lin();
        for (int k = 0; k < LINE; k++) write_ref(k, k);
    endtask

    task automatic send_mv(int pos, int frac);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        mv_valid = 1'b1;
        mv_pos   = pos[7:0];
        mv_frac  = frac[1:0];
        while (!acc && n < 50) begin
            acc = mv_ready;
            tick();
            n++;
        end
        mv_valid = 1'b0;
        if (!acc) dchk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(string name);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while ((busy || pred_valid || sb.size() > 0) && n < 300) begin
            if (busy && mv_ready) bad = 1;
            tick();
            n++;
        end
        dchk({name, "_mv_ready_low_while_busy"}, bad, 0);
        if (n >= 300) dchk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int base;
        int n;
        int pos;
        rst = 1'b1; ref_we = 1'b0; ref_addr = '0; ref_data = '0;
        mv_valid = 1'b0; mv_pos = '0; mv_frac = '0;
        tick();
        tick();
        dchk("rst_mv_ready", mv_ready, 1);
        dchk("rst_pred_valid", pred_valid, 0);
        dchk("rst_pred_data", pred_data, 0);
        dchk("rst_pred_last", pred_last, 0);
        dchk("rst_busy", busy, 0);
        rst = 1'b0;
        fill_lin();

        // integer position, first-data latency
        push_block(100, 0);
        send_mv(100, 0);
        dchk("lat_e0_valid", pred_valid, 0);
        tick();
        dchk("lat_e1_valid", pred_valid, 1);
        dchk("lat_e1_data", pred_data, 100);
        wait_idle("c1");

        // half-pel
        push_block(100, 2);
        send_mv(100, 2);
        wait_idle("c2");

        // backpressure after 2nd pixel
        push_block(100, 0);
        send_mv(100, 0);
        tick();
        tick();
        force_low = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            dchk("stall_valid", pred_valid, 1);
            dchk("stall_data", pred_data, 101);
        end
        force_low = 1'b0;
        wait_idle("c5");

        // quarter-pel with constant expectations
        for (int k = 0; k < 64; k++) write_ref(k, 4 * k);
        for (int j = 0; j < BLK; j++) push_exp(41 + 4 * j, j == BLK - 1);
        send_mv(10, 1);
        wait_idle("c3");

        // line-end clamp
        fill_lin();
`ifdef QPEL_MC_ROUND_EN
        for (int j = 0; j < BLK; j++) push_exp((251 + j > 255) ? 255 : 251 + j, j == BLK - 1);
`else
        push_block(250, 3);
`endif
        send_mv(250, 3);
        wait_idle("c4");

        // reset mid-block
        push_block(100, 0);
        send_mv(100, 0);
        base = popped;
        n = 0;
        while (popped < base + 4 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) dchk("c6_pop_timeout", 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        dchk("mid_rst_pred_valid", pred_valid, 0);
        dchk("mid_rst_busy", busy, 0);
        dchk("mid_rst_mv_ready", mv_ready, 1);
        push_block(0, 0);
        send_mv(0, 0);
        wait_idle("c6");

        // reset wins over a simultaneous request
        rst = 1'b1;
        mv_valid = 1'b1;
        tick();
        rst = 1'b0;
        mv_valid = 1'b0;
        dchk("rst_mv_busy", busy, 0);
        dchk("rst_mv_ready", mv_ready, 1);

        // writes ignored while busy
        push_block(20, 0);
        send_mv(20, 0);
        ref_we = 1'b1; ref_addr = 8'd30; ref_data = 8'hAA;
        tick();
        tick();
        ref_we = 1'b0;
        wait_idle("wg1");
        push_block(26, 0);
        send_mv(26, 0);
        wait_idle("wg2");

        // randomized blocks with random backpressure
        for (int k = 0; k < LINE; k++) write_ref(k, int'($urandom_range(0, 255)));
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            pos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(240, 255))
                                              : int'($urandom_range(0, 255));
            n = int'($urandom_range(0, 3));
            push_block(pos, n);
            send_mv(pos, n);
            wait_idle("rnd");
        end
        rand_rdy = 1'b0;

        dchk("sb_empty", sb.size(), 0);
        tick();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
